read_write_logic_dbb: RTL and testbench



---
 rtl/pic_pkg.sv | 24 ++
 rtl/pic_sync.sv | 31 +++
 rtl/read_write_logic_dbb.sv | 150 +++++++++++++++
 tb/tb_read_write_logic_dbb.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259A-compatible read/write logic and
// data bus buffer.
package pic_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_ICW2,
      WAIT_ICW3,
      WAIT_ICW4,
      READY
   } seq_state_t;

   localparam logic [2:0] SEL_IRR  = 3'd0;
   localparam logic [2:0] SEL_ISR  = 3'd1;
   localparam logic [2:0] SEL_IMR  = 3'd2;
   localparam logic [2:0] SEL_VEC  = 3'd3;
   localparam logic [2:0] SEL_POLL = 3'd4;

   localparam int ICW1_D4 = 4;
   localparam int OCW3_D3 = 3;
   localparam int IC4     = 0;
   localparam int SNGL    = 1;

endpackage

// File: rtl/pic_sync.sv
// N-flop synchronizer for an idle-high CPU strobe, with rising-edge detect
// taken after the last synchronizer stage.
module pic_sync #(
   parameter int   N    = 2,
   parameter logic INIT = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise
);

   logic [N-1:0] stages;
   logic         q_prev;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         stages <= {N{INIT}};
         q_prev <= INIT;
      end else begin
         stages <= {stages[N-2:0], d};
         q_prev <= stages[N-1];
      end
   end

   assign q    = stages[N-1];
   assign rise = q & ~q_prev;

endmodule

// File: rtl/read_write_logic_dbb.sv
// 8259A read/write control and data bus buffer: captures CPU writes,
// classifies them as ICW/OCW, and drives the selected status byte on reads.
module read_write_logic_dbb
   import pic_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rdn,
   input  logic       wrn,
   input  logic       A0,
   input  logic       CSn,
   input  logic [2:0] cadr,
   inout  wire  [7:0] WR,
   output logic       wrflg,
   output logic       rdflag,
   output logic       b0,
   output logic [7:0] wdata,
   input  logic [7:0] irr_in,
   input  logic [7:0] isr_in,
   input  logic [7:0] imr_in,
   input  logic [7:0] vec_in,
   input  logic [7:0] poll_in,
   output logic       icw1_wr,
   output logic       icw2_wr,
   output logic       icw3_wr,
   output logic       icw4_wr,
   output logic       ocw1_wr,
   output logic       ocw2_wr,
   output logic       ocw3_wr,
   output logic       init_done
);

   logic rd_s, wr_s, cs_s;
   logic rd_rise, wr_rise, cs_rise;
   logic unused_rise;

   pic_sync #(.N(SYNC_STAGES), .INIT(1'b1)) u_rd_sync (.clk(clk), .rst(rst), .d(rdn), .q(rd_s), .rise(rd_rise));
   pic_sync #(.N(SYNC_STAGES), .INIT(1'b1)) u_wr_sync (.clk(clk), .rst(rst), .d(wrn), .q(wr_s), .rise(wr_rise));
   pic_sync #(.N(SYNC_STAGES), .INIT(1'b1)) u_cs_sync (.clk(clk), .rst(rst), .d(CSn), .q(cs_s), .rise(cs_rise));

   assign unused_rise = rd_rise | cs_rise;

   logic capture;
   assign capture = wr_rise & ~cs_s;

   // A read is only honoured while the write strobe is idle, so a collision never drives the bus.
   assign rdflag = ~cs_s & ~rd_s & wr_s;

   logic [2:0] sel;
   logic [7:0] rd_mux;
   logic [7:0] rd_data;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      rd_mux = 8'h00;
      sel    = A0 ? SEL_IMR : cadr;
      case (sel)
         SEL_IRR:  rd_mux = irr_in;
         SEL_ISR:  rd_mux = isr_in;
         SEL_IMR:  rd_mux = imr_in;
         SEL_VEC:  rd_mux = vec_in;
         SEL_POLL: rd_mux = poll_in;
         default:  rd_mux = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) rd_data <= 8'h00;
      else     rd_data <= rd_mux;
   end

   assign WR = rdflag ? rd_data : 8'hzz;

   seq_state_t state;
   logic       sngl, ic4;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sngl      <= 1'b0;
         ic4       <= 1'b0;
         init_done <= 1'b0;
         wrflg     <= 1'b0;
         wdata     <= 8'h00;
         b0        <= 1'b0;
         icw1_wr   <= 1'b0;
         icw2_wr   <= 1'b0;
         icw3_wr   <= 1'b0;
         icw4_wr   <= 1'b0;
         ocw1_wr   <= 1'b0;
         ocw2_wr   <= 1'b0;
         ocw3_wr   <= 1'b0;
      end else begin
         wrflg   <= 1'b0;
         icw1_wr <= 1'b0;
         icw2_wr <= 1'b0;
         icw3_wr <= 1'b0;
         icw4_wr <= 1'b0;
         ocw1_wr <= 1'b0;
         ocw2_wr <= 1'b0;
         ocw3_wr <= 1'b0;
         if (capture) begin
            wrflg <= 1'b1;
            wdata <= WR;
            b0    <= A0;
            if (!A0 && WR[ICW1_D4]) begin
               icw1_wr   <= 1'b1;
               sngl      <= WR[SNGL];
               ic4       <= WR[IC4];
               init_done <= 1'b0;
               state     <= WAIT_ICW2;
            end else if (A0) begin
               case (state)
                  WAIT_ICW2: begin
                     icw2_wr <= 1'b1;
                     if (!sngl)    state <= WAIT_ICW3;
                     else if (ic4) state <= WAIT_ICW4;
                     else begin
                        state     <= READY;
                        init_done <= 1'b1;
                     end
                  end
                  WAIT_ICW3: begin
                     icw3_wr <= 1'b1;
                     if (ic4) state <= WAIT_ICW4;
                     else begin
                        state     <= READY;
                        init_done <= 1'b1;
                     end
                  end
                  WAIT_ICW4: begin
                     icw4_wr   <= 1'b1;
                     state     <= READY;
                     init_done <= 1'b1;
                  end
                  READY:   ocw1_wr <= 1'b1;
                  default: ;
               endcase
            end else if (state == READY) begin
               // D4=0 command writes are only meaningful once initialized.
               if (WR[OCW3_D3]) ocw3_wr <= 1'b1;
               else             ocw2_wr <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_read_write_logic_dbb.sv
// Randomized self-checking bench for read_write_logic_dbb against a queue-based
// model of the ICW/OCW initialization sequence and the read-source table.
module tb_read_write_logic_dbb;

   logic       clk = 1'b0;
   logic       rst, rdn, wrn, A0, CSn;
   logic [2:0] cadr;
   wire  [7:0] WR;
   logic [7:0] bus_drv;
   logic       bus_oe;
   logic       wrflg, rdflag, b0, init_done;
   logic [7:0] wdata;
   logic [7:0] irr_in, isr_in, imr_in, vec_in, poll_in;
   logic       icw1_wr, icw2_wr, icw3_wr, icw4_wr, ocw1_wr, ocw2_wr, ocw3_wr;
   logic [6:0] pulses;

   int n_checks = 0;
   int n_pass   = 0;

   // Model: ICW types still owed after ICW1 (2,3,4), and whether init finished.
   int pend[$];
   bit done_m;

   always #5 clk = ~clk;

   assign WR     = bus_oe ? bus_drv : 8'hzz;
   assign pulses = {ocw3_wr, ocw2_wr, ocw1_wr, icw4_wr, icw3_wr, icw2_wr, icw1_wr};

   read_write_logic_dbb #(.SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .rdn(rdn), .wrn(wrn), .A0(A0), .CSn(CSn), .cadr(cadr),
      .WR(WR), .wrflg(wrflg), .rdflag(rdflag), .b0(b0), .wdata(wdata),
      .irr_in(irr_in), .isr_in(isr_in), .imr_in(imr_in), .vec_in(vec_in), .poll_in(poll_in),
      .icw1_wr(icw1_wr), .icw2_wr(icw2_wr), .icw3_wr(icw3_wr), .icw4_wr(icw4_wr),
      .ocw1_wr(ocw1_wr), .ocw2_wr(ocw2_wr), .ocw3_wr(ocw3_wr), .init_done(init_done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // Type codes: 0 none, 1..4 ICW1..ICW4, 5..7 OCW1..OCW3, 99 more than one pulse.
   function automatic int enc(input logic [6:0] p);
      if (p == 7'd0) return 0;
      for (int i = 0; i < 7; i++) if (p == (7'd1 << i)) return i + 1;
      return 99;
   endfunction

   task automatic model_write(input bit a0, input logic [7:0] d, output int t);
      t = 0;
      if (!a0 && d[4]) begin
         pend.delete();
         pend.push_back(2);
         if (!d[1]) pend.push_back(3);
         if (d[0])  pend.push_back(4);
         done_m = 1'b0;
         t = 1;
      end else if (a0) begin
         if (pend.size() > 0) begin
            t = pend.pop_front();
            if (pend.size() == 0) done_m = 1'b1;
         end else if (done_m) begin
            t = 5;
         end
      end else if (done_m) begin
         t = d[3] ? 7 : 6;
      end
   endtask

   function automatic logic [7:0] model_read(input bit a0, input logic [2:0] c);
      if (a0) return imr_in;
      case (c)
         3'd0:    return irr_in;
         3'd1:    return isr_in;
         3'd2:    return imr_in;
         3'd3:    return vec_in;
         3'd4:    return poll_in;
         default: return 8'h00;
      endcase
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      pend.delete();
      done_m = 1'b0;
      check("rst_wrflg", wrflg, 0);
      check("rst_rdflag", rdflag, 0);
      check("rst_b0", b0, 0);
      check("rst_wdata", wdata, 8'h00);
      check("rst_init_done", init_done, 0);
      check("rst_pulses", pulses, 0);
   endtask

   // One CPU write strobe; optional deselect, long hold, and simultaneous read strobe.
   task automatic do_write(input bit a0, input logic [7:0] d, input bit sel = 1'b1,
                           input int hold = 3, input bit with_rd = 1'b0);
      int flg_cnt, hold_flg, stray, rd_seen, typ, exp_t;
      logic [7:0] wd;
      logic       bb;
      flg_cnt = 0; hold_flg = 0; stray = 0; rd_seen = 0; typ = 0; wd = 8'h00; bb = 1'b0;
      @(negedge clk);
      CSn = ~sel; A0 = a0; bus_drv = d; bus_oe = 1'b1; wrn = 1'b0;
      if (with_rd) rdn = 1'b0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (wrflg) hold_flg++;
         if (rdflag) rd_seen++;
      end
      wrn = 1'b1;
      rdn = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (rdflag) rd_seen++;
         if (wrflg) begin
            flg_cnt++;
            typ = enc(pulses);
            wd  = wdata;
            bb  = b0;
         end else if (|pulses) begin
            stray++;
         end
      end
      CSn = 1'b1;
      bus_oe = 1'b0;
      check("wr_hold_no_pulse", hold_flg, 0);
      check("wr_stray_type_pulse", stray, 0);
      check("wr_no_read_drive", rd_seen, 0);
      if (sel) begin
         model_write(a0, d, exp_t);
         check("wr_wrflg_once", flg_cnt, 1);
         check("wr_type", typ, exp_t);
         check("wr_wdata", wd, d);
         check("wr_b0", bb, a0);
         check("wr_init_done", init_done, done_m);
      end else begin
         check("wr_deselect_no_capture", flg_cnt, 0);
      end
   endtask

   task automatic do_read(input bit a0, input logic [2:0] c);
      int wait_on, wait_off;
      irr_in = 8'($urandom); isr_in = 8'($urandom); imr_in = 8'($urandom);
      vec_in = 8'($urandom); poll_in = 8'($urandom);
      @(negedge clk);
      CSn = 1'b0; A0 = a0; cadr = c; rdn = 1'b0;
      wait_on = 0;
      while (!rdflag && wait_on < 8) begin
         @(negedge clk);
         wait_on++;
      end
      check("rd_flag_rise", rdflag, 1);
      @(negedge clk);
      check("rd_data", WR, model_read(a0, c));
      rdn = 1'b1;
      wait_off = 0;
      while (rdflag && wait_off < 4) begin
         @(negedge clk);
         wait_off++;
      end
      check("rd_release", rdflag, 0);
      check("rd_release_latency_ok", (wait_off <= 3), 1);
      CSn = 1'b1;
   endtask

   initial begin
      int idle_bad;
      int r;
      logic [7:0] d;
      rst = 1'b1; rdn = 1'b1; wrn = 1'b1; A0 = 1'b0; CSn = 1'b1; cadr = 3'd0;
      bus_drv = 8'h00; bus_oe = 1'b0;
      irr_in = 8'h00; isr_in = 8'h00; imr_in = 8'h00; vec_in = 8'h00; poll_in = 8'h00;
      pend.delete();
      done_m = 1'b0;
      do_reset();

      // Deselected bus activity is invisible.
      A0 = 1'b1; cadr = 3'b111; bus_drv = 8'hAA; bus_oe = 1'b1;
      idle_bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (wrflg || rdflag || (|pulses)) idle_bad++;
      end
      bus_oe = 1'b0;
      check("idle_quiet", idle_bad, 0);
      check("idle_wdata", wdata, 8'h00);
      check("idle_b0", b0, 0);
      do_write(1'b1, 8'h55, 1'b0);

      // Full init then OCWs, then ICW1 mid-run.
      do_write(1'b0, 8'h11);
      do_write(1'b1, 8'h20);
      do_write(1'b1, 8'h04);
      do_write(1'b1, 8'h01);
      do_write(1'b1, 8'hFF);
      do_write(1'b0, 8'h20);
      do_write(1'b0, 8'h0A);
      do_write(1'b0, 8'h13, 1'b1, 10);
      check("icw1_midrun_clears_done", init_done, 0);

      // Single mode without ICW4.
      do_write(1'b0, 8'h12);
      do_write(1'b1, 8'h40);
      check("single_done", init_done, 1);

      // Read mux directed values.
      do_read(1'b0, 3'b000);
      do_read(1'b0, 3'b001);
      do_read(1'b1, 3'b000);
      do_read(1'b0, 3'b111);

      // Collision: write completes, bus never driven.
      do_write(1'b0, 8'h0A, 1'b1, 4, 1'b1);

      // Reset while waiting for ICW3 discards the sequence.
      do_write(1'b0, 8'h10);
      do_write(1'b1, 8'h30);
      do_reset();
      do_write(1'b1, 8'h77);

      // Randomized traffic.
      for (int i = 0; i < 150; i++) begin
         r = $urandom_range(0, 19);
         d = 8'($urandom);
         if (r < 4) begin
            d[4] = 1'b1;
            do_write(1'b0, d);
         end else if (r < 10) begin
            do_write(1'b1, d);
         end else if (r < 13) begin
            d[4] = 1'b0;
            do_write(1'b0, d);
         end else if (r < 18) begin
            do_read(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
         end else if (r == 18) begin
            do_write(1'($urandom_range(0, 1)), d, 1'b1, 3, 1'b1);
         end else begin
            do_reset();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
